// File: rtl/q_sel_pkg.sv
// rtl/q_sel_pkg.sv - shared widths, FSM encoding and latency for the action selector
package q_sel_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int STATE_WIDTH = 8;
    localparam int LATENCY     = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } sel_state_t;

endpackage

// File: rtl/q_action_select_max4to1.sv
// rtl/q_action_select_max4to1.sv - combinational signed maximum of four values
module max4to1_16bit #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] max_out
);

    logic signed [W-1:0] max_ab;
    logic signed [W-1:0] max_cd;

    always_comb begin
        max_ab  = (a >= b) ? a : b;
        max_cd  = (c >= d) ? c : d;
        max_out = (max_ab >= max_cd) ? max_ab : max_cd;
    end

endmodule

// File: rtl/q_action_select.sv
// rtl/q_action_select.sv - epsilon-greedy action selection over four Q-memory entries
module q_action_select #(
    parameter int DATA_WIDTH  = q_sel_pkg::DATA_WIDTH,
    parameter int STATE_WIDTH = q_sel_pkg::STATE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [STATE_WIDTH-1:0]        state_addr,
    input  logic [15:0]                   rand_in,
    input  logic [15:0]                   epsilon,
    output logic                          q_rd_en,
    output logic [STATE_WIDTH+1:0]        q_rd_addr,
    input  logic signed [DATA_WIDTH-1:0]  q_rd_data,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    action,
    output logic signed [DATA_WIDTH-1:0]  q_max,
    output logic                          explored
);

    import q_sel_pkg::*;

    sel_state_t                  state;
    logic [15:0]                 rand_l;
    logic [15:0]                 eps_l;
    logic signed [DATA_WIDTH-1:0] q_reg [4];
    logic                        rd_pending;
    logic [1:0]                  cap_idx;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic [1:0]                  greedy;
    logic                        explore_c;

    max4to1_16bit #(.W(DATA_WIDTH)) u_max (
        .a       (q_reg[0]),
        .b       (q_reg[1]),
        .c       (q_reg[2]),
        .d       (q_reg[3]),
        .max_out (max_val)
    );

    // Priority order makes ties resolve to the lowest action index.
    always_comb begin
        greedy = 2'd3;
        if (q_reg[0] == max_val)      greedy = 2'd0;
        else if (q_reg[1] == max_val) greedy = 2'd1;
        else if (q_reg[2] == max_val) greedy = 2'd2;
        explore_c = (rand_l < eps_l);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            q_rd_en    <= 1'b0;
            q_rd_addr  <= '0;
            action     <= 2'd0;
            q_max      <= '0;
            explored   <= 1'b0;
            rand_l     <= '0;
            eps_l      <= '0;
            rd_pending <= 1'b0;
            cap_idx    <= 2'd0;
            for (int i = 0; i < 4; i++) q_reg[i] <= '0;
        end else begin
            // Read data trails the strobe by one cycle, so capture follows the address pipeline.
            rd_pending <= q_rd_en;
            cap_idx    <= q_rd_addr[1:0];
            if (rd_pending) q_reg[cap_idx] <= q_rd_data;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        q_rd_en   <= 1'b1;
                        q_rd_addr <= {state_addr, 2'd0};
                        rand_l    <= rand_in;
                        eps_l     <= epsilon;
                    end
                end
                S_READ: begin
                    if (q_rd_addr[1:0] == 2'd3) begin
                        q_rd_en <= 1'b0;
                        state   <= S_WAIT;
                    end else begin
                        q_rd_addr[1:0] <= q_rd_addr[1:0] + 2'd1;
                    end
                end
                S_WAIT: state <= S_CALC;
                S_CALC: begin
                    q_max    <= max_val;
                    explored <= explore_c;
                    action   <= explore_c ? rand_l[1:0] : greedy;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_action_select.sv
// tb/tb_q_action_select.sv - directed table, reset corner cases and LFSR-driven random checks
module tb_q_action_select;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         state_addr;
    logic [15:0]        rand_in;
    logic [15:0]        epsilon;
    logic               q_rd_en;
    logic [9:0]         q_rd_addr;
    logic signed [15:0] q_rd_data;
    logic               busy;
    logic               done;
    logic [1:0]         action;
    logic signed [15:0] q_max;
    logic               explored;

    logic signed [15:0] mem [1024];
    int                 n_checks = 0;
    int                 n_err    = 0;

    always #5 clk = ~clk;

    q_action_select dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .state_addr (state_addr),
        .rand_in    (rand_in),
        .epsilon    (epsilon),
        .q_rd_en    (q_rd_en),
        .q_rd_addr  (q_rd_addr),
        .q_rd_data  (q_rd_data),
        .busy       (busy),
        .done       (done),
        .action     (action),
        .q_max      (q_max),
        .explored   (explored)
    );

    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= mem[q_rd_addr];
    end

    typedef struct {
        logic [7:0]         st;
        logic signed [15:0] q0, q1, q2, q3;
        logic [15:0]        rnd;
        logic [15:0]        eps;
        logic [1:0]         exp_action;
        logic signed [15:0] exp_qmax;
        logic               exp_explored;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] st, input logic signed [15:0] q0, q1, q2, q3);
        mem[{st, 2'd0}] = q0;
        mem[{st, 2'd1}] = q1;
        mem[{st, 2'd2}] = q2;
        mem[{st, 2'd3}] = q3;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, busy},     32'd0);
        chk({tag, "_done"},   {31'd0, done},     32'd0);
        chk({tag, "_rd_en"},  {31'd0, q_rd_en},  32'd0);
        chk({tag, "_rd_addr"}, {22'd0, q_rd_addr}, 32'd0);
        chk({tag, "_action"}, {30'd0, action},   32'd0);
        chk({tag, "_q_max"},  {16'd0, q_max},    32'd0);
        chk({tag, "_explored"}, {31'd0, explored}, 32'd0);
    endtask

    // Full operation from start at cycle 0 through cycle 8, sampled on falling edges.
    task automatic run_op(input string tag, input logic [7:0] st, input logic [15:0] rnd,
                          input logic [15:0] eps, input logic [1:0] exp_a,
                          input logic signed [15:0] exp_q, input logic exp_x);
        @(negedge clk);
        start = 1'b1; state_addr = st; rand_in = rnd; epsilon = eps;
        @(negedge clk);
        start = 1'b0; state_addr = ~st; rand_in = ~rnd; epsilon = ~eps;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_rd"}, {21'd0, q_rd_en, q_rd_addr}, {21'd0, 1'b1, st, i[1:0]});
            @(negedge clk);
        end
        chk({tag, "_wait_rd"}, {21'd0, q_rd_en, q_rd_addr}, {21'd0, 1'b0, st, 2'd3});
        chk({tag, "_early_done"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_early_done"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_action"}, {30'd0, action}, {30'd0, exp_a});
        chk({tag, "_q_max"}, {16'd0, q_max}, {16'd0, exp_q});
        chk({tag, "_explored"}, {31'd0, explored}, {31'd0, exp_x});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, {13'd0, action, q_max, explored}, {13'd0, exp_a, exp_q, exp_x});
    endtask

    logic [15:0]        lfsr;
    logic signed [15:0] rq [4];
    logic signed [15:0] ref_max;
    logic [1:0]         ref_arg;
    logic [15:0]        r_eps;
    logic               ref_x;
    logic [7:0]         r_st;
    int                 seen_done;

    initial begin
        vecs[0] = '{8'h05, 16'sd100, -16'sd20, 16'sd300, 16'sd7, 16'h1234, 16'h0000, 2'd2, 16'sd300, 1'b0};
        vecs[1] = '{8'h10, -16'sd5, -16'sd5, -16'sd5, -16'sd5, 16'h0000, 16'h0000, 2'd0, -16'sd5, 1'b0};
        vecs[2] = '{8'h20, 16'sh8000, -16'sd1, 16'sh8000, -16'sd2, 16'h0000, 16'h0000, 2'd1, -16'sd1, 1'b0};
        vecs[3] = '{8'h30, 16'sd9, 16'sd1, 16'sd1, 16'sd1, 16'h0003, 16'h0100, 2'd3, 16'sd9, 1'b1};
        vecs[4] = '{8'hFF, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'hFFFF, 16'hFFFF, 2'd3, 16'sd4, 1'b0};
        vecs[5] = '{8'h00, 16'sd50, 16'sd60, 16'sd60, 16'sd10, 16'hFFFE, 16'hFFFF, 2'd2, 16'sd60, 1'b1};
        vecs[6] = '{8'h41, 16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sh8000, 16'h0005, 16'h0005, 2'd0, 16'sh7FFF, 1'b0};
        vecs[7] = '{8'h42, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'h8000, 16'h8001, 2'd0, 16'sh8000, 1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; state_addr = '0; rand_in = '0; epsilon = '0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        for (int v = 0; v < 8; v++) begin
            load(vecs[v].st, vecs[v].q0, vecs[v].q1, vecs[v].q2, vecs[v].q3);
            run_op($sformatf("vec%0d", v), vecs[v].st, vecs[v].rnd, vecs[v].eps,
                   vecs[v].exp_action, vecs[v].exp_qmax, vecs[v].exp_explored);
        end

        // Start held again in cycle 3 must be ignored.
        load(8'h07, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
        @(negedge clk);
        start = 1'b1; state_addr = 8'h07; rand_in = 16'h0; epsilon = 16'h0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_action", {14'd0, action, q_max}, {14'd0, 2'd3, 16'sd4});
        @(negedge clk);
        chk("ign_busy8", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("ign_busy9", {31'd0, busy | done | q_rd_en}, 32'd0);

        // Reset in cycle 4 of an operation aborts it with no done.
        load(8'h08, 16'sd5, 16'sd6, 16'sd7, 16'sd8);
        @(negedge clk);
        start = 1'b1; state_addr = 8'h08;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("midrst_no_done", seen_done, 0);
        check_zero("midrst_after");
        run_op("after_rst", 8'h08, 16'h0, 16'h0, 2'd3, 16'sd8, 1'b0);

        lfsr = 16'hACE1;
        for (int n = 0; n < 1000; n++) begin
            r_st = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: rq[i] = 16'sh8000;
                    1: rq[i] = 16'($urandom_range(0, 3));
                    default: rq[i] = 16'($urandom);
                endcase
            end
            r_eps = (n % 4 == 0) ? 16'h0 : 16'($urandom);
            ref_max = rq[0]; ref_arg = 2'd0;
            for (int i = 1; i < 4; i++) begin
                if (rq[i] > ref_max) begin
                    ref_max = rq[i];
                    ref_arg = 2'(i);
                end
            end
            ref_x = (lfsr < r_eps);
            load(r_st, rq[0], rq[1], rq[2], rq[3]);
            run_op("rand", r_st, lfsr, r_eps, ref_x ? lfsr[1:0] : ref_arg, ref_max, ref_x);
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
